// File: rtl/uart_mem_pkg.sv
// Shared constants for the UART-to-memory command engine: opcodes, status byte,
// state encoding and the address-byte count helper.
package uart_mem_pkg;

  localparam logic [1:0] OP_READ     = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_WARMBOOT = 2'b10;
  localparam logic [1:0] OP_PING     = 2'b11;

  localparam logic [7:0] STATUS_OK = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_LEN,
    S_GET_DATA,
    S_WR,
    S_RD_REQ,
    S_RD_WAIT,
    S_TX_WORD,
    S_TX_CSUM,
    S_TX_STATUS,
    S_BOOT
  } state_e;

  // Number of address bytes the host sends for a given address width.
  function automatic int addr_bytes(input int addr_w);
    return (addr_w + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_mem_engine_if.sv
// UART byte stream and memory-fabric bus between the command engine (slave)
// and the surrounding UART pair / memory (master).
interface uart_mem_engine_if #(
  parameter int DATA_BYTES      = 2,
  parameter int ADDR_W          = 14,
  parameter int MEM_SELECT_BITS = 4
);
  logic                         uart_rx_valid;
  logic [7:0]                   uart_rx_data;
  logic                         uart_tx_busy;
  logic                         uart_tx_en;
  logic [7:0]                   uart_tx_data;
  logic [MEM_SELECT_BITS-1:0]   mem_select;
  logic [ADDR_W-1:0]            mem_addr;
  logic [8*DATA_BYTES-1:0]      mem_wdata;
  logic [8*DATA_BYTES-1:0]      mem_rdata;
  logic                         mem_rd_en;
  logic                         mem_wr_en;

  modport slave (
    input  uart_rx_valid, uart_rx_data, uart_tx_busy, mem_rdata,
    output uart_tx_en, uart_tx_data, mem_select, mem_addr, mem_wdata,
           mem_rd_en, mem_wr_en
  );

  modport master (
    output uart_rx_valid, uart_rx_data, uart_tx_busy, mem_rdata,
    input  uart_tx_en, uart_tx_data, mem_select, mem_addr, mem_wdata,
           mem_rd_en, mem_wr_en
  );
endinterface

// File: rtl/uart_tx_sender.sv
// Transmit handshake: issues one registered strobe per accepted byte and holds
// off long enough for the transmitter to raise busy before the next one.
module uart_tx_sender (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] byte_i,
  input  logic       uart_tx_busy,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  output logic       done
);

  logic       en_q, en_d;
  logic [7:0] data_q, data_d;
  logic [1:0] hold_q, hold_d;

  // hold covers the strobe cycle plus one cycle for busy to appear
  always_comb begin
    done   = 1'b0;
    en_d   = 1'b0;
    data_d = data_q;
    hold_d = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
    if (send && !uart_tx_busy && hold_q == 2'd0) begin
      done   = 1'b1;
      en_d   = 1'b1;
      data_d = byte_i;
      hold_d = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= 1'b0;
      data_q <= 8'h00;
      hold_q <= 2'd0;
    end else begin
      en_q   <= en_d;
      data_q <= data_d;
      hold_q <= hold_d;
    end
  end

  assign uart_tx_en   = en_q;
  assign uart_tx_data = data_q;

endmodule

// File: rtl/uart_mem_engine.sv
// Framed host command decoder driving burst reads/writes on the memory fabric,
// with per-command checksum/status reply and inter-byte timeout abort.
module uart_mem_engine
  import uart_mem_pkg::*;
#(
  parameter int         DATA_BYTES      = 2,
  parameter int         ADDR_W          = 14,
  parameter int         MEM_SELECT_BITS = 4,
  parameter int         LEN_W           = 16,
  parameter int         READ_LATENCY    = 1,
  parameter int         TIMEOUT_CYCLES  = 1200000,
  parameter logic [7:0] VERSION         = 8'h02
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_mem_engine_if.slave     bus,
  output logic                 warmboot,
  output logic                 busy,
  output logic                 error,
  output logic [2:0]           leds
);

  localparam int W    = 8 * DATA_BYTES;
  localparam int AB   = addr_bytes(ADDR_W);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                     state_q, state_d;
  logic [1:0]                 op_q, op_d;
  logic [MEM_SELECT_BITS-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [W-1:0]               word_q, word_d;
  logic [7:0]                 csum_q, csum_d;
  logic [7:0]                 bcnt_q, bcnt_d;
  logic [TO_W-1:0]            tmo_q, tmo_d;
  logic                       error_q, error_d;
  logic                       warmboot_q, warmboot_d;

  logic       send, tx_done, timed_out, rx;
  logic [7:0] tx_byte, b;

  assign rx = bus.uart_rx_valid;
  assign b  = bus.uart_rx_data;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    len_d      = len_q;
    word_d     = word_q;
    csum_d     = csum_q;
    bcnt_d     = bcnt_q;
    error_d    = error_q;
    warmboot_d = warmboot_q;
    send       = 1'b0;
    tx_byte    = 8'h00;

    if (rx || !(state_q inside {S_GET_ADDR, S_GET_LEN, S_GET_DATA, S_WR}))
      tmo_d = '0;
    else
      tmo_d = tmo_q + TO_W'(1);
    timed_out = !rx && (state_q inside {S_GET_ADDR, S_GET_LEN, S_GET_DATA}) &&
                (tmo_q == TO_W'(TIMEOUT_CYCLES - 1));

    if (timed_out) begin
      state_d = S_IDLE;
      error_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (rx) begin
          error_d = 1'b0;
          op_d    = b[7:6];
          sel_d   = b[MEM_SELECT_BITS-1:0];
          csum_d  = 8'h00;
          bcnt_d  = 8'd0;
          case (b[7:6])
            OP_PING: begin
              // PING reuses the checksum slot to carry the version byte
              csum_d  = VERSION;
              state_d = S_TX_CSUM;
            end
            OP_WARMBOOT: state_d = S_TX_STATUS;
            default:     state_d = S_GET_ADDR;
          endcase
        end
        S_GET_ADDR: if (rx) begin
          addr_d = ADDR_W'({addr_q, b});
          if (bcnt_q == 8'(AB - 1)) begin
            bcnt_d  = 8'd0;
            state_d = S_GET_LEN;
          end else bcnt_d = bcnt_q + 8'd1;
        end
        S_GET_LEN: if (rx) begin
          len_d = LEN_W'({len_q, b});
          if (bcnt_q == 8'd1) begin
            bcnt_d  = 8'd0;
            state_d = (op_q == OP_READ) ? S_RD_REQ : S_GET_DATA;
          end else bcnt_d = bcnt_q + 8'd1;
        end
        S_GET_DATA: if (rx) begin
          word_d = W'({word_q, b});
          csum_d = csum_q + b;
          if (bcnt_q == 8'(DATA_BYTES - 1)) begin
            bcnt_d  = 8'd0;
            state_d = S_WR;
          end else bcnt_d = bcnt_q + 8'd1;
        end
        S_WR: begin
          addr_d = addr_q + ADDR_W'(1);
          if (len_q == '0) state_d = S_TX_CSUM;
          else begin
            len_d   = len_q - LEN_W'(1);
            state_d = S_GET_DATA;
            // a byte landing in the write cycle starts the next word
            if (rx) begin
              word_d = W'({word_q, b});
              csum_d = csum_q + b;
              if (DATA_BYTES == 1) state_d = S_WR;
              else bcnt_d = 8'd1;
            end
          end
        end
        S_RD_REQ: begin
          bcnt_d  = 8'd0;
          state_d = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (bcnt_q == 8'(READ_LATENCY - 1)) begin
            word_d  = bus.mem_rdata;
            bcnt_d  = 8'd0;
            state_d = S_TX_WORD;
          end else bcnt_d = bcnt_q + 8'd1;
        end
        S_TX_WORD: begin
          send    = 1'b1;
          tx_byte = word_q[W-1 -: 8];
          if (tx_done) begin
            csum_d = csum_q + tx_byte;
            word_d = W'({word_q, 8'h00});
            if (bcnt_q == 8'(DATA_BYTES - 1)) begin
              bcnt_d = 8'd0;
              addr_d = addr_q + ADDR_W'(1);
              if (len_q == '0) state_d = S_TX_CSUM;
              else begin
                len_d   = len_q - LEN_W'(1);
                state_d = S_RD_REQ;
              end
            end else bcnt_d = bcnt_q + 8'd1;
          end
        end
        S_TX_CSUM: begin
          send    = 1'b1;
          tx_byte = csum_q;
          if (tx_done) state_d = S_TX_STATUS;
        end
        S_TX_STATUS: begin
          send    = 1'b1;
          tx_byte = STATUS_OK;
          if (tx_done) begin
            bcnt_d  = 8'd0;
            state_d = (op_q == OP_WARMBOOT) ? S_BOOT : S_IDLE;
          end
        end
        S_BOOT: begin
          // let the last strobe and its holdoff pass before trusting busy
          if (bcnt_q != 8'd2) bcnt_d = bcnt_q + 8'd1;
          else if (!bus.uart_tx_busy) warmboot_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_READ;
      sel_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      word_q     <= '0;
      csum_q     <= 8'h00;
      bcnt_q     <= 8'd0;
      tmo_q      <= '0;
      error_q    <= 1'b0;
      warmboot_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      bcnt_q     <= bcnt_d;
      tmo_q      <= tmo_d;
      error_q    <= error_d;
      warmboot_q <= warmboot_d;
    end
  end

  uart_tx_sender u_tx (
    .clk          (clk),
    .reset        (reset),
    .send         (send),
    .byte_i       (tx_byte),
    .uart_tx_busy (bus.uart_tx_busy),
    .uart_tx_en   (bus.uart_tx_en),
    .uart_tx_data (bus.uart_tx_data),
    .done         (tx_done)
  );

  assign bus.mem_select = sel_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = word_q;
  assign bus.mem_wr_en  = (state_q == S_WR);
  assign bus.mem_rd_en  = (state_q == S_RD_REQ);

  assign warmboot = warmboot_q;
  assign error    = error_q;
  assign busy     = (state_q != S_IDLE);
  assign leds     = {error_q, busy, warmboot_q};

endmodule
